// File: rtl/decim_frame_scheduler.sv
// decim_frame_scheduler
// Decimates an incoming sample stream by a runtime factor (1..16) and writes
// every kept sample into a two-bank frame RAM. Completed frames are offered to
// the pitch detector with a valid/ack handshake. When both banks are held by
// the consumer side the scheduler stalls, dropping and counting kept samples.
//
// Ports:
//   clk, reset              rising-edge clock, asynchronous active-high reset
//   start, stop             capture control pulses (stop wins over start)
//   decim_sel               decimation factor minus one, latched per frame
//   audio_valid, audio_in   input sample stream
//   wr_en/wr_bank/wr_addr/wr_data   frame RAM write port (registered)
//   frame_valid, frame_bank, frame_ack   frame handoff to the consumer
//   busy                    capture state machine is not idle
//   overrun, drop_count     sticky drop flag and saturating drop counter
module decim_frame_scheduler #(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned FRAME_LEN = 256,
  parameter int unsigned AW        = $clog2(FRAME_LEN)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic [3:0]        decim_sel,
  input  logic              audio_valid,
  input  logic [DATA_W-1:0] audio_in,
  output logic              wr_en,
  output logic              wr_bank,
  output logic [AW-1:0]     wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              frame_valid,
  output logic              frame_bank,
  input  logic              frame_ack,
  output logic              busy,
  output logic              overrun,
  output logic [15:0]       drop_count
);

  localparam logic [AW-1:0] LastAddr = AW'(FRAME_LEN - 1);

  typedef enum logic [1:0] {StIdle, StCapture, StStall} state_e;

  state_e              state_q, state_d;
  logic [3:0]          phase_q, phase_d;
  logic [3:0]          factor_q, factor_d;
  logic                wr_en_q, wr_en_d;
  logic                wr_bank_q, wr_bank_d;
  logic [AW-1:0]       wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]   wr_data_q, wr_data_d;
  logic                frame_valid_q, frame_valid_d;
  logic                frame_bank_q, frame_bank_d;
  logic                overrun_q, overrun_d;
  logic [15:0]         drop_count_q, drop_count_d;

  logic keep, ack_eff, frame_done, other_free, drop;

  // Phase >= factor (rather than ==) keeps decimation well defined when a
  // smaller factor is re-latched while the phase is already past it.
  assign keep       = audio_valid && (state_q != StIdle) && (phase_q >= factor_q);
  assign ack_eff    = frame_ack && frame_valid_q;
  // The frame completes in the cycle its last address is on the write port.
  assign frame_done = (state_q == StCapture) && wr_en_q && (wr_addr_q == LastAddr) && !stop;
  assign other_free = !frame_valid_q || frame_ack;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (start) state_d = StCapture;
      StCapture: if (frame_done && !other_free) state_d = StStall;
      StStall:   if (ack_eff) state_d = StCapture;
      default:   state_d = StIdle;
    endcase
    if (stop) state_d = StIdle;
  end

  // Output logic
  always_comb begin
    busy = (state_q != StIdle);
  end

  // Datapath next-state
  always_comb begin
    phase_d       = phase_q;
    factor_d      = factor_q;
    wr_en_d       = 1'b0;
    wr_bank_d     = wr_bank_q;
    wr_addr_d     = wr_addr_q;
    wr_data_d     = wr_data_q;
    frame_valid_d = frame_valid_q;
    frame_bank_d  = frame_bank_q;
    overrun_d     = overrun_q;
    drop_count_d  = drop_count_q;
    drop          = 1'b0;

    // Address advances the cycle after each write.
    if (wr_en_q) wr_addr_d = wr_addr_q + AW'(1);
    if (audio_valid && (state_q != StIdle)) phase_d = keep ? 4'd0 : phase_q + 4'd1;
    if (ack_eff) frame_valid_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start && !stop) begin
          phase_d      = 4'd0;
          factor_d     = decim_sel;
          wr_bank_d    = 1'b0;
          wr_addr_d    = '0;
          overrun_d    = 1'b0;
          drop_count_d = 16'd0;
        end
      end
      StCapture: begin
        if (frame_done) begin
          wr_addr_d = '0;
          factor_d  = decim_sel;
          if (other_free) begin
            frame_valid_d = 1'b1;
            frame_bank_d  = wr_bank_q;
            wr_bank_d     = ~wr_bank_q;
          end
          // Otherwise the full bank stays parked in wr_bank as the queued frame.
        end
        if (keep && !stop) begin
          if (frame_done && !other_free) begin
            drop = 1'b1;
          end else begin
            wr_en_d   = 1'b1;
            wr_data_d = audio_in;
          end
        end
      end
      StStall: begin
        if (keep && !stop) drop = 1'b1;
        if (ack_eff && !stop) begin
          // Queued bank becomes the offer; the acked bank is refilled.
          frame_valid_d = 1'b1;
          frame_bank_d  = wr_bank_q;
          wr_bank_d     = frame_bank_q;
          wr_addr_d     = '0;
        end
      end
      default: ;
    endcase

    if (stop) phase_d = 4'd0;

    if (drop) begin
      overrun_d = 1'b1;
      if (drop_count_q != 16'hFFFF) drop_count_d = drop_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_q       <= 4'd0;
      factor_q      <= 4'd0;
      wr_en_q       <= 1'b0;
      wr_bank_q     <= 1'b0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
      frame_valid_q <= 1'b0;
      frame_bank_q  <= 1'b0;
      overrun_q     <= 1'b0;
      drop_count_q  <= 16'd0;
    end else begin
      phase_q       <= phase_d;
      factor_q      <= factor_d;
      wr_en_q       <= wr_en_d;
      wr_bank_q     <= wr_bank_d;
      wr_addr_q     <= wr_addr_d;
      wr_data_q     <= wr_data_d;
      frame_valid_q <= frame_valid_d;
      frame_bank_q  <= frame_bank_d;
      overrun_q     <= overrun_d;
      drop_count_q  <= drop_count_d;
    end
  end

  assign wr_en       = wr_en_q;
  assign wr_bank     = wr_bank_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign frame_valid = frame_valid_q;
  assign frame_bank  = frame_bank_q;
  assign overrun     = overrun_q;
  assign drop_count  = drop_count_q;

endmodule

// File: tb/tb_decim_frame_scheduler.sv
// Bench for decim_frame_scheduler with an 8-sample frame: a hand-written
// vector table, directed multi-cycle sequences and a random run, all shadowed
// by a frame-level reference model.
module tb_decim_frame_scheduler;

  localparam int FL = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, stop, audio_valid, frame_ack;
  logic [3:0]  decim_sel;
  logic [15:0] audio_in;
  logic        wr_en, wr_bank, frame_valid, frame_bank, busy, overrun;
  logic [2:0]  wr_addr;
  logic [15:0] wr_data, drop_count;

  int n_tests = 0;
  int n_fail  = 0;

  decim_frame_scheduler #(.DATA_W(16), .FRAME_LEN(FL)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .decim_sel(decim_sel),
    .audio_valid(audio_valid), .audio_in(audio_in), .wr_en(wr_en), .wr_bank(wr_bank),
    .wr_addr(wr_addr), .wr_data(wr_data), .frame_valid(frame_valid),
    .frame_bank(frame_bank), .frame_ack(frame_ack), .busy(busy), .overrun(overrun),
    .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  // Reference model: counts samples since the last keep, fills frames by
  // count, and tracks which frame is offered and whether one is queued.
  bit m_busy, m_stall, m_pend, m_fv, m_fb, m_bank, m_ovr, m_we, m_wb;
  int m_F, m_cnt, m_fill, m_drops, m_wa, m_wd;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_stall = 0; m_pend = 0; m_fv = 0; m_fb = 0; m_bank = 0;
    m_ovr = 0; m_we = 0; m_wb = 0; m_F = 1; m_cnt = 0; m_fill = 0;
    m_drops = 0; m_wa = 0; m_wd = 0;
  endtask

  task automatic model_drop();
    m_ovr = 1;
    if (m_drops < 65535) m_drops++;
  endtask

  task automatic model_step(input int st, input int sp, input int av, input int din,
                            input int dsel, input int ack);
    bit ack_eff, keep, entering;
    ack_eff  = (ack != 0) && m_fv;
    entering = 0;
    m_we     = 0;
    if (sp != 0) begin
      if (ack_eff) m_fv = 0;
      m_busy = 0; m_stall = 0; m_pend = 0; m_cnt = 0;
    end else if (!m_busy) begin
      if (ack_eff) m_fv = 0;
      if (st != 0) begin
        m_busy = 1; m_F = dsel + 1; m_cnt = 0; m_fill = 0; m_bank = 0;
        m_drops = 0; m_ovr = 0;
      end
    end else begin
      keep = (av != 0) && (m_cnt + 1 >= m_F);
      if (av != 0) m_cnt = keep ? 0 : m_cnt + 1;
      if (m_stall) begin
        if (keep) model_drop();
        if (ack_eff) begin
          m_stall = 0;
          {m_fb, m_bank} = {m_bank, m_fb};
          m_fill = 0;
        end
      end else begin
        if (m_pend) begin
          m_pend = 0; m_F = dsel + 1; m_fill = 0;
          if (!m_fv || ack != 0) begin
            m_fv = 1; m_fb = m_bank; m_bank = !m_bank;
          end else begin
            m_stall = 1; entering = 1;
          end
        end else if (ack_eff) begin
          m_fv = 0;
        end
        if (keep) begin
          if (entering) begin
            model_drop();
          end else begin
            m_we = 1; m_wb = m_bank; m_wa = m_fill; m_wd = din & 16'hFFFF;
            m_fill++;
            if (m_fill == FL) m_pend = 1;
          end
        end
      end
    end
  endtask

  task automatic model_check();
    chk("m.busy", int'(busy), int'(m_busy));
    chk("m.wr_en", int'(wr_en), int'(m_we));
    if (m_we) begin
      chk("m.wr_bank", int'(wr_bank), int'(m_wb));
      chk("m.wr_addr", int'(wr_addr), m_wa);
      chk("m.wr_data", int'(wr_data), m_wd);
    end
    chk("m.frame_valid", int'(frame_valid), int'(m_fv));
    if (m_fv) chk("m.frame_bank", int'(frame_bank), int'(m_fb));
    chk("m.overrun", int'(overrun), int'(m_ovr));
    chk("m.drop_count", int'(drop_count), m_drops);
  endtask

  task automatic tick(input int st, input int sp, input int av, input int din,
                      input int dsel, input int ack);
    start       = (st != 0);
    stop        = (sp != 0);
    audio_valid = (av != 0);
    audio_in    = 16'(din);
    decim_sel   = 4'(dsel);
    frame_ack   = (ack != 0);
    model_step(st, sp, av, din, dsel, ack);
    @(posedge clk);
    #1;
    model_check();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    start = 0; stop = 0; audio_valid = 0; audio_in = 0; decim_sel = 0; frame_ack = 0;
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " busy"}, int'(busy), 0);
    chk({tag, " wr_en"}, int'(wr_en), 0);
    chk({tag, " wr_bank"}, int'(wr_bank), 0);
    chk({tag, " wr_addr"}, int'(wr_addr), 0);
    chk({tag, " wr_data"}, int'(wr_data), 0);
    chk({tag, " frame_valid"}, int'(frame_valid), 0);
    chk({tag, " frame_bank"}, int'(frame_bank), 0);
    chk({tag, " overrun"}, int'(overrun), 0);
    chk({tag, " drop_count"}, int'(drop_count), 0);
  endtask

  typedef struct {
    bit st, sp, av;
    int din, dsel;
    bit ack;
    bit e_busy, e_we;
    int e_addr, e_data;
    bit e_fv;
  } vec_t;

  function automatic vec_t mkv(input int st, input int sp, input int av, input int din,
                               input int dsel, input int ack, input int eb, input int ew,
                               input int ea, input int ed, input int efv);
    vec_t v;
    v.st = (st != 0); v.sp = (sp != 0); v.av = (av != 0); v.din = din; v.dsel = dsel;
    v.ack = (ack != 0); v.e_busy = (eb != 0); v.e_we = (ew != 0); v.e_addr = ea;
    v.e_data = ed; v.e_fv = (efv != 0);
    return v;
  endfunction

  vec_t tbl[11];

  initial begin
    //              st sp av din   dsel ack | busy we addr data  fv
    tbl[0]  = mkv(1, 0, 0, 0,    0, 0,   1, 0, 0, 0,    0);
    tbl[1]  = mkv(0, 0, 1, 'h11, 0, 0,   1, 1, 0, 'h11, 0);
    tbl[2]  = mkv(0, 0, 1, 'h22, 0, 0,   1, 1, 1, 'h22, 0);
    tbl[3]  = mkv(0, 0, 0, 0,    0, 0,   1, 0, 2, 'h22, 0);
    tbl[4]  = mkv(0, 1, 0, 0,    0, 0,   0, 0, 2, 'h22, 0);
    tbl[5]  = mkv(1, 1, 0, 0,    0, 0,   0, 0, 2, 'h22, 0);
    tbl[6]  = mkv(1, 0, 0, 0,    1, 0,   1, 0, 0, 'h22, 0);
    tbl[7]  = mkv(0, 0, 1, 1,    1, 0,   1, 0, 0, 'h22, 0);
    tbl[8]  = mkv(0, 0, 1, 2,    1, 0,   1, 1, 0, 2,    0);
    tbl[9]  = mkv(0, 0, 0, 0,    1, 0,   1, 0, 1, 2,    0);
    tbl[10] = mkv(0, 1, 0, 0,    1, 0,   0, 0, 1, 2,    0);

    // Reset state
    do_reset();
    chk_all_zero("reset");

    // Table-driven vectors
    for (int i = 0; i < 11; i++) begin
      tick(tbl[i].st, tbl[i].sp, tbl[i].av, tbl[i].din, tbl[i].dsel, tbl[i].ack);
      chk($sformatf("tbl%0d busy", i), int'(busy), int'(tbl[i].e_busy));
      chk($sformatf("tbl%0d wr_en", i), int'(wr_en), int'(tbl[i].e_we));
      chk($sformatf("tbl%0d wr_addr", i), int'(wr_addr), tbl[i].e_addr);
      chk($sformatf("tbl%0d wr_data", i), int'(wr_data), tbl[i].e_data);
      chk($sformatf("tbl%0d frame_valid", i), int'(frame_valid), int'(tbl[i].e_fv));
    end

    // Basic fill, F=4
    do_reset();
    tick(1, 0, 0, 0, 3, 0);
    for (int i = 0; i < 32; i++) tick(0, 0, 1, i, 3, 0);
    chk("fill last wr_en", int'(wr_en), 1);
    chk("fill last wr_data", int'(wr_data), 31);
    chk("fill last wr_addr", int'(wr_addr), 7);
    chk("fill last wr_bank", int'(wr_bank), 0);
    chk("fill fv early", int'(frame_valid), 0);
    tick(0, 0, 0, 0, 3, 0);
    chk("fill frame_valid", int'(frame_valid), 1);
    chk("fill frame_bank", int'(frame_bank), 0);

    // Ping-pong handoff
    tick(0, 0, 0, 0, 3, 1);
    chk("pp ack clears", int'(frame_valid), 0);
    for (int i = 0; i < 64; i++) begin
      tick(0, 0, 1, 32 + i, 3, 0);
      if (i == 31) begin
        chk("pp bank1 last data", int'(wr_data), 63);
        chk("pp bank1 last bank", int'(wr_bank), 1);
      end
    end
    tick(0, 0, 0, 0, 3, 0);
    chk("pp frame_bank", int'(frame_bank), 1);
    chk("pp overrun", int'(overrun), 0);

    // Stall and overrun, then async reset mid-capture
    do_reset();
    tick(1, 0, 0, 0, 3, 0);
    for (int i = 0; i < 96; i++) tick(0, 0, 1, i, 3, 0);
    chk("stall drop_count", int'(drop_count), 8);
    chk("stall overrun", int'(overrun), 1);
    chk("stall frame_bank", int'(frame_bank), 0);
    tick(0, 0, 0, 0, 3, 1);
    chk("stall ack fv", int'(frame_valid), 1);
    chk("stall ack frame_bank", int'(frame_bank), 1);
    for (int i = 96; i < 100; i++) tick(0, 0, 1, i, 3, 0);
    chk("resume wr_en", int'(wr_en), 1);
    chk("resume wr_bank", int'(wr_bank), 0);
    chk("resume wr_addr", int'(wr_addr), 0);
    chk("resume wr_data", int'(wr_data), 99);
    reset = 1'b1;
    #1;
    chk_all_zero("async reset");
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Ack coinciding with the last write of the other bank, then stop
    tick(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) tick(0, 0, 1, i, 0, 0);
    tick(0, 0, 1, 16, 0, 1);
    chk("simul fv", int'(frame_valid), 1);
    chk("simul frame_bank", int'(frame_bank), 1);
    chk("simul drop_count", int'(drop_count), 0);
    chk("simul wr_bank", int'(wr_bank), 0);
    chk("simul wr_addr", int'(wr_addr), 0);
    chk("simul wr_data", int'(wr_data), 16);
    for (int i = 17; i < 22; i++) tick(0, 0, 1, i, 0, 0);
    chk("stop at addr", int'(wr_addr), 5);
    tick(0, 1, 1, 22, 0, 0);
    chk("stop busy", int'(busy), 0);
    chk("stop fv held", int'(frame_valid), 1);
    tick(0, 0, 0, 0, 0, 0);
    chk("stop fv held 2", int'(frame_valid), 1);
    tick(0, 0, 0, 0, 0, 1);
    chk("stop ack", int'(frame_valid), 0);

    // Factor change 3 -> 0 mid-frame
    do_reset();
    tick(1, 0, 0, 0, 3, 0);
    for (int i = 0; i < 12; i++) tick(0, 0, 1, i, 3, 0);
    tick(0, 0, 1, 12, 0, 0);
    chk("fchg no keep", int'(wr_en), 0);
    for (int i = 13; i < 33; i++) tick(0, 0, 1, i, 0, 0);
    tick(0, 0, 1, 33, 0, 0);
    chk("fchg new wr_bank", int'(wr_bank), 1);
    chk("fchg new wr_addr", int'(wr_addr), 0);
    chk("fchg new wr_data", int'(wr_data), 33);
    tick(0, 0, 1, 34, 0, 0);
    chk("fchg every wr_data", int'(wr_data), 34);
    chk("fchg every wr_addr", int'(wr_addr), 1);

    // Random run against the model
    begin
      int dsel;
      dsel = 1;
      do_reset();
      tick(1, 0, 0, 0, dsel, 0);
      for (int i = 0; i < 3000; i++) begin
        if ($urandom_range(0, 19) == 0) dsel = ($urandom_range(0, 7) == 0) ?
                                               int'($urandom_range(0, 15)) :
                                               int'($urandom_range(0, 3));
        tick(int'($urandom_range(0, 39) == 0), int'($urandom_range(0, 149) == 0),
             int'($urandom_range(0, 3) != 0), int'($urandom_range(0, 65535)), dsel,
             int'($urandom_range(0, 9) == 0));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
